and_gate_unit: RTL and testbench
================================

Name: and_gate_unit

Overview:
- Parameterised bitwise two-input AND block; the leaf logic primitive of the CPU datapath.
- Combinational output `out = a & b` is available with zero latency; with WIDTH=1 it is the classic 1-bit AND gate.
- Adds a clocked, valid-qualified pipelined copy of the result and reduction flags for use by registered datapath consumers.

Parameters:
- WIDTH, 1, operand and result bit width (1..64).
- PIPE_STAGES, 1, register stages on the registered path (1..4).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out  output  WIDTH  combinational result `a & b`.
- in_valid  input  1  qualifies a/b for the registered path.
- out_q  output  WIDTH  registered result after PIPE_STAGES cycles.
- out_valid  output  1  out_q holds a valid result.
- all_ones  output  1  reduction AND of out_q, gated by out_valid.
- all_zero  output  1  out_q == 0, gated by out_valid.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (ports clk and rst_n).
- out:
  - Purely combinational: `out[i] = a[i] & b[i]` for every bit.
  - Independent of clk, rst_n and in_valid; valid even while in reset.
  - X/Z on an input bit follows Verilog `&` semantics.
- Registered path:
  - Stage 0 captures `a & b` and in_valid on each rising clk edge.
  - Each subsequent stage shifts data and valid forward.
  - out_q and out_valid come from the last stage.
  - Latency is exactly PIPE_STAGES cycles from an in_valid sample to the matching out_valid.
- No backpressure: a new operand may be accepted every cycle.
- Data registers load unconditionally; out_q is meaningful only when out_valid = 1.
- Flags:
  - `all_ones = out_valid & (&out_q)`.
  - `all_zero = out_valid & ~(|out_q)`.
  - Both are 0 when out_valid = 0.
- Reset:
  - Asserting rst_n = 0 immediately (asynchronously) clears all stage data to 0, all valid bits to 0, all_ones = 0 and all_zero = 0.
  - Deassertion takes effect at the next rising clk edge.
  - Reset mid-stream discards every in-flight result; no partial results emerge after release.
- Boundaries:
  - in_valid pulses on consecutive cycles produce consecutive out_valid pulses, in order, with no drops.
  - WIDTH=1 reduces both flags to `out_q` and `~out_q` (when valid).

Optional Feature:
- Macro: AND_GATE_UNIT_STATS_EN.
- When defined:
  - Adds output `result_count [15:0]`, counting cycles with out_valid = 1 and saturating at 16'hFFFF.
  - Adds output `ones_count [15:0]`, counting valid cycles with all_ones = 1, also saturating.
  - Both counters clear to 0 on async reset.
- When undefined:
  - The ports and counter logic do not exist.
  - All other behaviour is identical.

Test Plan:
- WIDTH=1 combinational truth table, one step per time unit: a=0,b=0→out=0; a=0,b=1→out=0; a=1,b=0→out=0; a=1,b=1→out=1. Update is immediate with no clock edges, and also holds with rst_n=0.
- WIDTH=8, PIPE_STAGES=1: a=8'hF0, b=8'h3C, in_valid=1 for one cycle → out=8'h30 at once; after 1 edge out_q=8'h30, out_valid=1, all_ones=0, all_zero=0; the next cycle out_valid=0.
- WIDTH=8, PIPE_STAGES=3: a=b=8'hFF then a=8'hAA, b=8'h55 on back-to-back valid cycles → after 3 edges out_q=8'hFF with all_ones=1; the next cycle out_q=8'h00 with all_zero=1.
- Reset mid-stream: with 2 valid results in flight (PIPE_STAGES=3), drop rst_n asynchronously between edges → out_valid, out_q, all_ones and all_zero go to 0 immediately; no valid outputs follow release without new in_valid.
- Stats (macro defined): 70000 consecutive valid all-ones operations → result_count=16'hFFFF and ones_count=16'hFFFF (saturated); reset clears both to 0.

Source files
------------

// File: rtl/and_gate_unit.sv
// and_gate_unit: bitwise two-input AND, the leaf logic primitive of the CPU datapath.
// A zero-latency combinational result is always available on `out`. Alongside it,
// a valid-qualified pipeline of PIPE_STAGES registers delivers the same result,
// plus all-ones and all-zero reduction flags, to registered datapath consumers.
// Optional statistics counters are compiled in when AND_GATE_UNIT_STATS_EN is defined.
`timescale 1ns/1ps

module and_gate_unit #(
  parameter int WIDTH       = 1,
  parameter int PIPE_STAGES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid,
  output logic             all_ones,
  output logic             all_zero
`ifdef AND_GATE_UNIT_STATS_EN
  ,
  output logic [15:0]      result_count,
  output logic [15:0]      ones_count
`endif
);

  // Per-stage data and valid. Index 0 is the capture stage and
  // PIPE_STAGES-1 is the stage that drives the outputs.
  logic [WIDTH-1:0]       data_q  [PIPE_STAGES];
  logic [WIDTH-1:0]       data_d  [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] valid_q;
  logic [PIPE_STAGES-1:0] valid_d;

  // Zero-latency result. It does not depend on clock, reset or in_valid, so it
  // remains usable while the unit is held in reset.
  always_comb begin
    out = a & b;
  end

  // Next-state values for the pipeline. Stage 0 loads the fresh product, and
  // every later stage takes the contents of the stage before it. The data
  // registers load on every cycle; valid tells consumers which entries matter.
  always_comb begin
    data_d[0]  = a & b;
    valid_d    = '0;
    valid_d[0] = in_valid;
    for (int i = 1; i < PIPE_STAGES; i++) begin
      data_d[i]  = data_q[i-1];
      valid_d[i] = valid_q[i-1];
    end
  end

  // Pipeline registers. The asynchronous reset clears every in-flight entry at
  // once, so no partial result can appear after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        data_q[i] <= '0;
      end
      valid_q <= '0;
    end else begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        data_q[i] <= data_d[i];
      end
      valid_q <= valid_d;
    end
  end

  // The last stage drives the registered outputs. Both flags are qualified by
  // valid, so they read 0 whenever out_q carries no meaningful result.
  always_comb begin
    out_q     = data_q[PIPE_STAGES-1];
    out_valid = valid_q[PIPE_STAGES-1];
    all_ones  = out_valid & (&out_q);
    all_zero  = out_valid & ~(|out_q);
  end

`ifdef AND_GATE_UNIT_STATS_EN
  logic [15:0] result_count_q;
  logic [15:0] result_count_d;
  logic [15:0] ones_count_q;
  logic [15:0] ones_count_d;

  // Saturating event counters. Each one stops at 16'hFFFF instead of wrapping,
  // so a long run can never report a small, misleading count.
  always_comb begin
    result_count_d = result_count_q;
    ones_count_d   = ones_count_q;
    if (out_valid && (result_count_q != 16'hFFFF)) begin
      result_count_d = result_count_q + 16'd1;
    end
    if (all_ones && (ones_count_q != 16'hFFFF)) begin
      ones_count_d = ones_count_q + 16'd1;
    end
  end

  // Counter registers, cleared together with the pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_count_q <= '0;
      ones_count_q   <= '0;
    end else begin
      result_count_q <= result_count_d;
      ones_count_q   <= ones_count_d;
    end
  end

  // Drive the counter ports from their registers.
  always_comb begin
    result_count = result_count_q;
    ones_count   = ones_count_q;
  end
`endif

endmodule

// File: tb/tb_and_gate_unit.sv
// tb_and_gate_unit: self-checking bench for and_gate_unit, using a 1-bit instance,
// an 8-bit single-stage instance and an 8-bit three-stage instance.
`timescale 1ns/1ps

module tb_and_gate_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       w1_a, w1_b, w1_in_valid;
  logic       w1_out, w1_out_q, w1_out_valid, w1_all_ones, w1_all_zero;

  logic [7:0] p1_a, p1_b, p1_out, p1_out_q;
  logic       p1_in_valid, p1_out_valid, p1_all_ones, p1_all_zero;

  logic [7:0] p3_a, p3_b, p3_out, p3_out_q;
  logic       p3_in_valid, p3_out_valid, p3_all_ones, p3_all_zero;

`ifdef AND_GATE_UNIT_STATS_EN
  logic [15:0] w1_result_count, w1_ones_count;
  logic [15:0] p1_result_count, p1_ones_count;
  logic [15:0] p3_result_count, p3_ones_count;
`endif

  and_gate_unit #(.WIDTH(1), .PIPE_STAGES(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(w1_a), .b(w1_b), .out(w1_out),
    .in_valid(w1_in_valid), .out_q(w1_out_q), .out_valid(w1_out_valid),
    .all_ones(w1_all_ones), .all_zero(w1_all_zero)
`ifdef AND_GATE_UNIT_STATS_EN
    , .result_count(w1_result_count), .ones_count(w1_ones_count)
`endif
  );

  and_gate_unit #(.WIDTH(8), .PIPE_STAGES(1)) u_p1 (
    .clk(clk), .rst_n(rst_n), .a(p1_a), .b(p1_b), .out(p1_out),
    .in_valid(p1_in_valid), .out_q(p1_out_q), .out_valid(p1_out_valid),
    .all_ones(p1_all_ones), .all_zero(p1_all_zero)
`ifdef AND_GATE_UNIT_STATS_EN
    , .result_count(p1_result_count), .ones_count(p1_ones_count)
`endif
  );

  and_gate_unit #(.WIDTH(8), .PIPE_STAGES(3)) u_p3 (
    .clk(clk), .rst_n(rst_n), .a(p3_a), .b(p3_b), .out(p3_out),
    .in_valid(p3_in_valid), .out_q(p3_out_q), .out_valid(p3_out_valid),
    .all_ones(p3_all_ones), .all_zero(p3_all_zero)
`ifdef AND_GATE_UNIT_STATS_EN
    , .result_count(p3_result_count), .ones_count(p3_ones_count)
`endif
  );

  typedef struct {
    logic [7:0] exp;
    int         due;
  } sb_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       v;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic a;
    logic b;
    logic exp;
  } tt_t;

  sb_t  sb_q [$];
  sb_t  mon_e;
  int   checks    = 0;
  int   failures  = 0;
  int   cycle_cnt = 0;
  bit   mon_en    = 1'b0;
  vec_t vecs [7];
  tt_t  tt   [4];

  // Cycle counter used to check pipeline latency.
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Compare one observed value against its expected value and count the result.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one operand pair into the three-stage instance just after a rising edge,
  // and record the expected result together with the cycle it is due.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic v, input logic [7:0] exp);
    sb_t e;
    @(posedge clk);
    #1;
    p3_a        = a;
    p3_b        = b;
    p3_in_valid = v;
    if (v) begin
      e.exp = exp;
      e.due = cycle_cnt + 3;
      sb_q.push_back(e);
    end
  endtask

  // Scoreboard monitor for the three-stage instance, sampled on the falling edge.
  always @(negedge clk) begin
    if (p3_out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checkOutput("p3_unexpected_valid", 64'(1), 64'(0));
      end else begin
        mon_e = sb_q.pop_front();
        checkOutput("p3_out_q", 64'(p3_out_q), 64'(mon_e.exp));
        checkOutput("p3_all_ones", 64'(p3_all_ones), 64'(&mon_e.exp));
        checkOutput("p3_all_zero", 64'(p3_all_zero), 64'(mon_e.exp == 8'h00));
        checkOutput("p3_latency", 64'(cycle_cnt), 64'(mon_e.due));
      end
    end else if (mon_en) begin
      checkOutput("p3_idle_flags", 64'({p3_all_ones, p3_all_zero}), 64'(0));
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tt[0] = '{1'b0, 1'b0, 1'b0};
    tt[1] = '{1'b0, 1'b1, 1'b0};
    tt[2] = '{1'b1, 1'b0, 1'b0};
    tt[3] = '{1'b1, 1'b1, 1'b1};

    vecs[0] = '{8'hFF, 8'hFF, 1'b1, 8'hFF};
    vecs[1] = '{8'hAA, 8'h55, 1'b1, 8'h00};
    vecs[2] = '{8'hF0, 8'h3C, 1'b1, 8'h30};
    vecs[3] = '{8'h5A, 8'h0F, 1'b0, 8'h0A};
    vecs[4] = '{8'hC3, 8'h81, 1'b1, 8'h81};
    vecs[5] = '{8'h12, 8'h34, 1'b1, 8'h10};
    vecs[6] = '{8'h7E, 8'hE7, 1'b1, 8'h66};

    rst_n = 1'b0;
    w1_a = 1'b0; w1_b = 1'b0; w1_in_valid = 1'b0;
    p1_a = 8'h00; p1_b = 8'h00; p1_in_valid = 1'b0;
    p3_a = 8'h00; p3_b = 8'h00; p3_in_valid = 1'b0;
    #2;

    // 1-bit truth table while reset is held, one step per time unit.
    for (int i = 0; i < 4; i++) begin
      w1_a = tt[i].a;
      w1_b = tt[i].b;
      #1;
      checkOutput("w1_comb_in_reset", 64'(w1_out), 64'(tt[i].exp));
    end

    // Reset state of the registered path.
    checkOutput("rst_p3_out_valid", 64'(p3_out_valid), 64'(0));
    checkOutput("rst_p3_out_q", 64'(p3_out_q), 64'(0));
    checkOutput("rst_p3_flags", 64'({p3_all_ones, p3_all_zero}), 64'(0));
    checkOutput("rst_p1_out_valid", 64'(p1_out_valid), 64'(0));
`ifdef AND_GATE_UNIT_STATS_EN
    checkOutput("rst_p1_result_count", 64'(p1_result_count), 64'(0));
`endif

    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // 1-bit truth table out of reset.
    for (int i = 0; i < 4; i++) begin
      w1_a = tt[i].a;
      w1_b = tt[i].b;
      #1;
      checkOutput("w1_comb", 64'(w1_out), 64'(tt[i].exp));
    end

    // 1-bit registered path: each flag collapses to out_q or its complement.
    @(posedge clk); #1;
    w1_a = 1'b1; w1_b = 1'b1; w1_in_valid = 1'b1;
    @(posedge clk); #2;
    checkOutput("w1_q_ones", 64'({w1_out_valid, w1_out_q, w1_all_ones, w1_all_zero}), 64'(4'b1110));
    w1_b = 1'b0;
    @(posedge clk); #2;
    checkOutput("w1_q_zero", 64'({w1_out_valid, w1_out_q, w1_all_ones, w1_all_zero}), 64'(4'b1001));
    w1_in_valid = 1'b0;
    @(posedge clk); #2;
    checkOutput("w1_q_idle", 64'({w1_out_valid, w1_all_ones, w1_all_zero}), 64'(0));

    // Single-stage instance: one valid operand pair.
    @(posedge clk); #1;
    p1_a = 8'hF0; p1_b = 8'h3C; p1_in_valid = 1'b1;
    #1;
    checkOutput("p1_comb", 64'(p1_out), 64'(8'h30));
    checkOutput("p1_not_yet_valid", 64'(p1_out_valid), 64'(0));
    @(posedge clk); #1;
    p1_in_valid = 1'b0;
    #1;
    checkOutput("p1_out_q", 64'(p1_out_q), 64'(8'h30));
    checkOutput("p1_out_valid", 64'(p1_out_valid), 64'(1));
    checkOutput("p1_flags", 64'({p1_all_ones, p1_all_zero}), 64'(0));
    @(posedge clk); #2;
    checkOutput("p1_valid_drops", 64'(p1_out_valid), 64'(0));
`ifdef AND_GATE_UNIT_STATS_EN
    @(posedge clk); #2;
    checkOutput("p1_result_count_one", 64'(p1_result_count), 64'(1));
    checkOutput("p1_ones_count_zero", 64'(p1_ones_count), 64'(0));
`endif

    // Three-stage instance, table-driven with back-to-back operand pairs.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].v, vecs[i].exp);
      #1;
      checkOutput("p3_comb", 64'(p3_out), 64'(vecs[i].exp));
    end
    applyStimulus(8'h00, 8'h00, 1'b0, 8'h00);
    repeat (5) @(posedge clk);
    #2;
    checkOutput("p3_drain", 64'(sb_q.size()), 64'(0));

    // Reset mid-stream: one result at the output and two more in flight.
    applyStimulus(8'hFF, 8'hFF, 1'b1, 8'hFF);
    applyStimulus(8'h0F, 8'hF0, 1'b1, 8'h00);
    applyStimulus(8'h3C, 8'h3C, 1'b1, 8'h3C);
    @(posedge clk); #1;
    p3_in_valid = 1'b0;
    #1;
    checkOutput("mid_pre_valid", 64'({p3_out_valid, p3_all_ones}), 64'(2'b11));
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", 64'(p3_out_valid), 64'(0));
    checkOutput("mid_rst_out_q", 64'(p3_out_q), 64'(0));
    checkOutput("mid_rst_all_ones", 64'(p3_all_ones), 64'(0));
    checkOutput("mid_rst_all_zero", 64'(p3_all_zero), 64'(0));
    sb_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #2;
      checkOutput("mid_no_ghost", 64'(p3_out_valid), 64'(0));
    end
    applyStimulus(8'hC3, 8'h3C, 1'b1, 8'h00);
    applyStimulus(8'h00, 8'h00, 1'b0, 8'h00);
    repeat (4) @(posedge clk);
    #2;
    checkOutput("mid_recover_drain", 64'(sb_q.size()), 64'(0));

`ifdef AND_GATE_UNIT_STATS_EN
    // Counter saturation over a long run of valid all-ones results.
    mon_en = 1'b0;
    @(posedge clk); #1;
    p1_a = 8'hFF; p1_b = 8'hFF; p1_in_valid = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    p1_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("stats_result_sat", 64'(p1_result_count), 64'(16'hFFFF));
    checkOutput("stats_ones_sat", 64'(p1_ones_count), 64'(16'hFFFF));
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("stats_result_rst", 64'(p1_result_count), 64'(0));
    checkOutput("stats_ones_rst", 64'(p1_ones_count), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
`endif

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
